// File: rtl/sig_pkg.sv
// Shared signal-controller definitions: country/highway light encodings and sensor defaults.
// Used by car_sensor_if and sig_control.
package sig_pkg;

  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;

  localparam int DEBOUNCE_DEF = 4;

  function automatic logic is_green(input logic [2:0] light);
    return light == LT_GREEN;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus debouncer for one raw inductive-loop input.
// rise/fall are combinational and high in the cycle whose closing edge flips the level.
module sensor_debounce
  import sig_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clock,
  input  logic clear,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          flip;

  // The DEBOUNCE-th consecutive disagreeing cycle flips the level at its closing edge.
  assign flip = (sync_2 != level) && (cnt == CW'(DEBOUNCE - 1));
  assign rise = flip && sync_2;
  assign fall = flip && !sync_2;

  always_ff @(posedge clock) begin
    if (clear) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == level || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (flip) begin
        level <= sync_2;
      end
    end
  end

endmodule

// File: rtl/car_sensor_if.sv
// Country-road car-present producer: debounced arrival/exit loops, queued-car counter, x output.
// Optional stuck-arrival-loop detector enabled by defining SENSOR_STUCK_DET_EN.
module car_sensor_if
  import sig_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CNT_W    = 4
`ifdef SENSOR_STUCK_DET_EN
  , parameter int STUCK_CYCLES = 1024
`endif
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic             exit_raw,
  input  logic [2:0]       crd,
  output logic             x,
  output logic [CNT_W-1:0] car_count,
  output logic             sat,
  output logic             fault
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic loop_level, loop_rise, loop_fall;
  logic exit_level, exit_rise, exit_fall;
  logic arrive, depart;

  logic [CNT_W-1:0] count_next;
  logic             sat_next;
  logic             fault_next;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_loop_deb (
    .clock (clock),
    .clear (clear),
    .raw   (loop_raw),
    .level (loop_level),
    .rise  (loop_rise),
    .fall  (loop_fall)
  );

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit_deb (
    .clock (clock),
    .clear (clear),
    .raw   (exit_raw),
    .level (exit_level),
    .rise  (exit_rise),
    .fall  (exit_fall)
  );

  assign arrive = loop_rise;
  // Exit-loop hits only count as departures while the country light is green.
  assign depart = exit_rise && is_green(crd);

  always_comb begin
    count_next = car_count;
    sat_next   = sat;
    if (arrive && !depart) begin
      if (car_count == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        count_next = car_count + 1'b1;
      end
    end else if (depart && !arrive && car_count != '0) begin
      count_next = car_count - 1'b1;
    end
  end

`ifdef SENSOR_STUCK_DET_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic [SW-1:0] stuck_cnt;

  always_ff @(posedge clock) begin
    if (clear || !loop_level) begin
      stuck_cnt <= '0;
    end else if (stuck_cnt != SW'(STUCK_CYCLES)) begin
      stuck_cnt <= stuck_cnt + 1'b1;
    end
  end

  always_comb begin
    fault_next = fault;
    if (loop_fall) begin
      fault_next = 1'b0;
    end else if (loop_level && stuck_cnt == SW'(STUCK_CYCLES - 1)) begin
      fault_next = 1'b1;
    end
  end

  logic unused_deb;
  assign unused_deb = ^{exit_level, exit_fall};
`else
  assign fault_next = 1'b0;

  logic unused_deb;
  assign unused_deb = ^{loop_level, loop_fall, exit_level, exit_fall};
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      car_count <= '0;
      sat       <= 1'b0;
      fault     <= 1'b0;
      x         <= 1'b0;
    end else begin
      car_count <= count_next;
      sat       <= sat_next;
      fault     <= fault_next;
      x         <= (count_next != '0) || fault_next;
    end
  end

endmodule

// File: tb/tb_car_sensor_if.sv
// Bench for car_sensor_if: directed scenarios with literal expectations, then random loop traffic
// compared every cycle against a sample-window reference model.
module tb_car_sensor_if;

  localparam int DEB     = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;
`ifdef SENSOR_STUCK_DET_EN
  localparam int STUCK = 16;
`endif

  logic          clock;
  logic          clear;
  logic          loop_raw;
  logic          exit_raw;
  logic [2:0]    crd;
  logic          x;
  logic [CW-1:0] car_count;
  logic          sat;
  logic          fault;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  car_sensor_if #(
    .DEBOUNCE (DEB),
    .CNT_W    (CW)
`ifdef SENSOR_STUCK_DET_EN
    , .STUCK_CYCLES (STUCK)
`endif
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .loop_raw  (loop_raw),
    .exit_raw  (exit_raw),
    .crd       (crd),
    .x         (x),
    .car_count (car_count),
    .sat       (sat),
    .fault     (fault)
  );

  // clock / reset
  initial clock = 0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Sync output seen at an edge is the raw value sampled two edges earlier (0 right after clear).
  // A level flips when the last DEB sync samples all disagree with it.
  int m_count;
  bit m_sat, m_fault;
  bit m_lvl_loop, m_lvl_exit;
  bit r1_loop, r2_loop, r1_exit, r2_exit;
  bit win_loop[$];
  bit win_exit[$];
  int m_high;

  function automatic bit all_differ(input bit w[$], input bit lvl);
    int n = 0;
    foreach (w[i]) if (w[i] != lvl) n++;
    return (w.size() == DEB) && (n == DEB);
  endfunction

  always @(posedge clock) begin
    bit s_loop, s_exit, arr, dep, lfall, lvl_before;
    if (clear) begin
      m_count = 0; m_sat = 0; m_fault = 0;
      m_lvl_loop = 0; m_lvl_exit = 0;
      r1_loop = 0; r2_loop = 0; r1_exit = 0; r2_exit = 0;
      win_loop.delete(); win_exit.delete();
      m_high = 0;
    end else begin
      s_loop = r2_loop; r2_loop = r1_loop; r1_loop = loop_raw;
      s_exit = r2_exit; r2_exit = r1_exit; r1_exit = exit_raw;
      win_loop.push_back(s_loop); if (win_loop.size() > DEB) void'(win_loop.pop_front());
      win_exit.push_back(s_exit); if (win_exit.size() > DEB) void'(win_exit.pop_front());
      lvl_before = m_lvl_loop;
      arr = 0; dep = 0; lfall = 0;
      if (all_differ(win_loop, m_lvl_loop)) begin
        m_lvl_loop = !m_lvl_loop;
        arr = m_lvl_loop;
        lfall = !m_lvl_loop;
      end
      if (all_differ(win_exit, m_lvl_exit)) begin
        m_lvl_exit = !m_lvl_exit;
        dep = m_lvl_exit && (crd == 3'b001);
      end
      if (arr && !dep) begin
        if (m_count == CNT_MAX) m_sat = 1;
        else m_count++;
      end else if (dep && !arr && m_count > 0) begin
        m_count--;
      end
      if (lvl_before) m_high++; else m_high = 0;
`ifdef SENSOR_STUCK_DET_EN
      if (lfall) m_fault = 0;
      else if (lvl_before && m_high == STUCK) m_fault = 1;
`else
      if (lfall) m_fault = 0;
`endif
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      check("model_count", int'(car_count), m_count);
      check("model_x", int'(x), int'((m_count != 0) || m_fault));
      check("model_sat", int'(sat), int'(m_sat));
      check("model_fault", int'(fault), int'(m_fault));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    clear = 1; loop_raw = 0; exit_raw = 0;
    step(2);
    clear = 0;
    step(2);
  endtask

  task automatic arrive_car();
    loop_raw = 1; step(8);
    loop_raw = 0; step(8);
  endtask

  task automatic exit_car(input logic [2:0] light);
    crd = light;
    exit_raw = 1; step(8);
    exit_raw = 0; step(8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear = 1; loop_raw = 1; exit_raw = 0; crd = 3'b100;

    // reset holds everything at zero even with the loop occupied
    step(1);
    chk_en = 1;
    check("rst_x", int'(x), 0);
    check("rst_count", int'(car_count), 0);
    step(1);
    check("rst_sat", int'(sat), 0);
    check("rst_fault", int'(fault), 0);
    loop_raw = 0;
    step(1);
    clear = 0;
    step(3);

    // 3-cycle glitch is filtered
    loop_raw = 1; step(3);
    loop_raw = 0; step(10);
    check("glitch_count", int'(car_count), 0);
    check("glitch_x", int'(x), 0);

    // arrival latency: count/x update at edge DEB+2 = 6
    loop_raw = 1;
    step(5);
    check("lat_e5_count", int'(car_count), 0);
    step(1);
    check("lat_e6_count", int'(car_count), 1);
    check("lat_e6_x", int'(x), 1);
    step(4);
    loop_raw = 0; step(8);
    exit_car(3'b001);
    check("exit_green_count", int'(car_count), 0);
    check("exit_green_x", int'(x), 0);
    exit_car(3'b001);
    check("underflow_count", int'(car_count), 0);

    // exits under red/yellow/other are not departures
    do_reset();
    arrive_car(); arrive_car();
    check("two_cars", int'(car_count), 2);
    exit_car(3'b100);
    check("exit_red", int'(car_count), 2);
    exit_car(3'b010);
    exit_car(3'b011);
    check("exit_yel_other", int'(car_count), 2);
    exit_car(3'b001);
    check("exit_green2_count", int'(car_count), 1);
    check("exit_green2_x", int'(x), 1);

    // saturation
    do_reset();
    for (int i = 0; i < 16; i++) arrive_car();
    check("sat_count", int'(car_count), 15);
    check("sat_flag", int'(sat), 1);

    // coincident arrive+depart under green
    do_reset();
    for (int i = 0; i < 5; i++) arrive_car();
    crd = 3'b001; loop_raw = 1; exit_raw = 1;
    step(8);
    loop_raw = 0; exit_raw = 0;
    step(8);
    check("coinc_count", int'(car_count), 5);
    check("coinc_sat", int'(sat), 0);

`ifdef SENSOR_STUCK_DET_EN
    // stuck arrival loop forces x while count is zero
    do_reset();
    loop_raw = 1; step(8);
    exit_car(3'b001);
    step(10);
    check("stuck_count", int'(car_count), 0);
    check("stuck_fault", int'(fault), 1);
    check("stuck_x", int'(x), 1);
    loop_raw = 0; step(8);
    check("stuck_clr_fault", int'(fault), 0);
    check("stuck_clr_x", int'(x), 0);
`endif

    // random traffic
    do_reset();
    for (int seg = 0; seg < 500; seg++) begin
      int n;
      loop_raw = 1'($urandom_range(0, 1));
      exit_raw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0, 1:    crd = 3'b001;
        2:       crd = 3'b010;
        3:       crd = 3'b100;
        default: crd = 3'($urandom_range(0, 7));
      endcase
      clear = ($urandom_range(0, 149) == 0);
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        step(1);
        clear = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
